// File: rtl/tmds_pkg.sv
// Shared TMDS encoder types, symbol tables and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL  = 3'd0,
    MODE_VIDEO = 3'd1,
    MODE_VGB   = 3'd2,
    MODE_DI    = 3'd3,
    MODE_DIGB  = 3'd4
  } tmds_mode_e;

  // Indexed by {c1,c0}.
  localparam logic [9:0] CTRL_WORD [0:3] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_WORD [0:15] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] VGB_CH02 = 10'b1011001100;
  localparam logic [9:0] VGB_CH1  = 10'b0100110011;
  localparam logic [9:0] DIGB_CH12 = 10'b0100110011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_dc_balance.sv
// Stage-2 video path: running-disparity DC balancing of q_m into a 10-bit word.
// Latency: word is combinational from q_m/cnt; cnt advances on each clk_pixel edge.
// Backpressure: none; one word per cycle.
// Ports: clk_pixel, reset (sync, active-high), video_en (stage-2 mode is video),
//        q_m[8:0] (transition-minimised byte), word[9:0] (balanced video symbol).
module tmds_dc_balance
  import tmds_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       video_en,
  input  logic [8:0] q_m,
  output logic [9:0] word
);

  logic signed [4:0] cnt;
  logic        [3:0] n1;
  logic signed [4:0] diff;   // n1 - n0 of q_m[7:0]
  logic signed [4:0] delta;

  always_comb begin
    n1    = popcount8(q_m[7:0]);
    // n1 - n0 == 2*n1 - 8; the 5-bit wrap is harmless since the result is within -8..8.
    diff  = $signed({n1, 1'b0}) - 5'sd8;
    word  = '0;
    delta = '0;
    if (cnt == 5'sd0 || n1 == 4'd4) begin
      word  = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      delta = q_m[8] ? diff : -diff;
    end else if ((cnt > 5'sd0 && n1 > 4'd4) || (cnt < 5'sd0 && n1 < 4'd4)) begin
      word  = {1'b1, q_m[8], ~q_m[7:0]};
      delta = (q_m[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      word  = {1'b0, q_m[8], q_m[7:0]};
      delta = diff - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  // Any non-video cycle restarts the disparity so each video run begins balanced.
  always_ff @(posedge clk_pixel) begin
    if (reset || !video_en) cnt <= '0;
    else                    cnt <= cnt + delta;
  end

endmodule

// File: rtl/tmds_channel.sv
// Per-channel TMDS encoder: video, control, TERC4 and guard-band symbols.
// Latency: fixed 2 cycles for every mode (stage-1 capture, stage-2 output register).
// Backpressure: none; accepts and emits one word per clk_pixel.
// Ports: clk_pixel, reset (sync, active-high), mode[2:0], video_data[7:0],
//        control_data[1:0], data_island_data[3:0], tmds[9:0] (bit 0 sent first).
module tmds_channel
  import tmds_pkg::*;
#(
  parameter int unsigned CN = 0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic [7:0] video_data,
  input  logic [1:0] control_data,
  input  logic [3:0] data_island_data,
  output logic [9:0] tmds
);

  // Stage 1: transition minimisation.
  logic [3:0] d_ones;
  logic       use_xnor;
  logic [8:0] q_m_d;

  always_comb begin
    d_ones   = popcount8(video_data);
    use_xnor = (d_ones > 4'd4) || (d_ones == 4'd4 && !video_data[0]);
    q_m_d    = '0;
    q_m_d[0] = video_data[0];
    for (int i = 1; i < 8; i++)
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ video_data[i]) : (q_m_d[i-1] ^ video_data[i]);
    q_m_d[8] = ~use_xnor;
  end

  tmds_mode_e mode_q;
  logic [8:0] q_m_q;
  logic [1:0] ctrl_q;
  logic [3:0] di_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      mode_q <= MODE_CTRL;
      q_m_q  <= '0;
      ctrl_q <= '0;
      di_q   <= '0;
    end else begin
      // Codes 5..7 collapse to control here so stage 2 only sees legal modes.
      mode_q <= (mode > 3'd4) ? MODE_CTRL : tmds_mode_e'(mode);
      q_m_q  <= q_m_d;
      ctrl_q <= control_data;
      di_q   <= data_island_data;
    end
  end

  // Stage 2: DC balance and final symbol select.
  logic [9:0] video_word;

  tmds_dc_balance u_dcb (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .video_en  (mode_q == MODE_VIDEO),
    .q_m       (q_m_q),
    .word      (video_word)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds <= CTRL_WORD[0];
    end else begin
      case (mode_q)
        MODE_VIDEO: tmds <= video_word;
        MODE_VGB:   tmds <= (CN == 1) ? VGB_CH1 : VGB_CH02;
        MODE_DI:    tmds <= TERC4_WORD[di_q];
        // Channel 0 keeps carrying HSYNC/VSYNC as TERC4 during the guard band.
        MODE_DIGB:  tmds <= (CN == 0) ? TERC4_WORD[di_q] : DIGB_CH12;
        default:    tmds <= CTRL_WORD[ctrl_q];
      endcase
    end
  end

endmodule
